// File: rtl/mem_access.sv
// mem_access: pipeline memory stage issuing one 64-bit bus transaction per load/store.
// Define MEM_ACCESS_MISALIGN_CHECK_EN to reject misaligned accesses instead of rounding them down.
package mem_access_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [6:0] op_code;
    logic [2:0] funct3;
  } decoder_output;
endpackage

module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                complete,
  input  decoder_output       control_signals,
  input  logic [ADDR_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]   store_data,
  output logic [ADDR_W-1:0]   alu_result_out,
  output logic [DATA_W-1:0]   mem_load_data,
  output logic                misaligned,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_write,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

  state_t              state, state_next;
  logic                is_load, is_store, is_mem, bad_align;
  logic [2:0]          off_raw, size_mask, off_eff;
  logic [DATA_W/8-1:0] lane_mask;
  logic                aborted, is_load_q;
  logic [2:0]          off_q, funct3_q;
  logic [DATA_W-1:0]   shifted, load_ext;

  always_comb begin
    is_load  = (control_signals.op_code == OP_LOAD);
    is_store = (control_signals.op_code == OP_STORE);
    is_mem   = is_load | is_store;
    off_raw  = alu_result[2:0];
    case (control_signals.funct3[1:0])
      2'b00:   begin size_mask = 3'b000; lane_mask = 8'h01; end
      2'b01:   begin size_mask = 3'b001; lane_mask = 8'h03; end
      2'b10:   begin size_mask = 3'b011; lane_mask = 8'h0F; end
      default: begin size_mask = 3'b111; lane_mask = 8'hFF; end
    endcase
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    bad_align = is_mem && ((off_raw & size_mask) != 3'b000);
    off_eff   = off_raw;
`else
    bad_align = 1'b0;
    off_eff   = off_raw & ~size_mask;
`endif
  end

  always_comb begin
    shifted = mem_resp_data >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_ext = {56'd0, shifted[7:0]};
      3'b101:  load_ext = {48'd0, shifted[15:0]};
      3'b110:  load_ext = {32'd0, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // An abandoned transaction still finishes on the bus but never reports completion.
  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    complete      = 1'b0;
    case (state)
      IDLE:      if (enable) state_next = (is_mem && !bad_align) ? REQ : DONE;
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = WAIT_RESP;
      end
      WAIT_RESP: if (mem_resp_valid) state_next = (aborted || !enable) ? IDLE : DONE;
      DONE: begin
        complete = enable;
        if (!enable) state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      alu_result_out <= '0;
      mem_load_data  <= '0;
      misaligned     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_write  <= 1'b0;
      mem_req_wdata  <= '0;
      mem_req_wstrb  <= '0;
      aborted        <= 1'b0;
      is_load_q      <= 1'b0;
      off_q          <= 3'd0;
      funct3_q       <= 3'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && enable) begin
        alu_result_out <= alu_result;
        mem_load_data  <= '0;
        misaligned     <= bad_align;
        mem_req_addr   <= {alu_result[ADDR_W-1:3], 3'b000};
        mem_req_write  <= is_store;
        mem_req_wdata  <= is_store ? (store_data << {off_eff, 3'b000}) : '0;
        mem_req_wstrb  <= is_store ? (lane_mask << off_eff) : '0;
        aborted        <= 1'b0;
        is_load_q      <= is_load;
        off_q          <= off_eff;
        funct3_q       <= control_signals.funct3;
      end
      if ((state == REQ || state == WAIT_RESP) && !enable) aborted <= 1'b1;
      if (state == WAIT_RESP && mem_resp_valid && is_load_q) mem_load_data <= load_ext;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors against a spec-level transaction model, checked every cycle.
// Honours MEM_ACCESS_MISALIGN_CHECK_EN the same way the design does.
module tb_mem_access;
  import mem_access_pkg::*;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  localparam bit CHECK_ALIGN = 1'b1;
`else
  localparam bit CHECK_ALIGN = 1'b0;
`endif
  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          complete;
  decoder_output ctrl;
  logic [63:0]   alu_result, store_data, alu_result_out, mem_load_data;
  logic          misaligned, mem_req_valid, mem_req_ready, mem_req_write;
  logic [63:0]   mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [7:0]    mem_req_wstrb;
  logic          mem_resp_valid;

  mem_access dut (
    .clk(clk), .reset(reset), .enable(enable), .complete(complete),
    .control_signals(ctrl), .alu_result(alu_result), .store_data(store_data),
    .alu_result_out(alu_result_out), .mem_load_data(mem_load_data), .misaligned(misaligned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_write(mem_req_write), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model expectations for the transaction in flight
  bit          m_req, m_write, m_mis, m_abort;
  logic [63:0] m_addr, m_wdata, m_load_val, m_alu;
  logic [7:0]  m_wstrb;
  int          cyc, req_last, resp_cyc, done_cyc;
  bit          active, txn_en, exp_valid;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_txn(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] sdata, input logic [63:0] rdata);
    int          off, nbytes, eff;
    bit          is_ld, is_st;
    logic [63:0] sh, keep;
    is_ld  = (op == OP_LOAD);
    is_st  = (op == OP_STORE);
    off    = int'(addr % 64'd8);
    nbytes = 1 << (int'(f3) % 4);
    eff    = off;
    m_mis  = 1'b0;
    if ((is_ld || is_st) && (off % nbytes != 0)) begin
      if (CHECK_ALIGN) m_mis = 1'b1;
      else eff = off - (off % nbytes);
    end
    m_req      = (is_ld || is_st) && !m_mis;
    m_addr     = addr - (addr % 64'd8);
    m_write    = is_st;
    m_wdata    = sdata << (8 * eff);
    m_wstrb    = 8'((((1 << nbytes) - 1) << eff) & 255);
    m_alu      = addr;
    m_load_val = 64'd0;
    if (is_ld && !m_mis) begin
      sh         = rdata >> (8 * eff);
      keep       = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
      m_load_val = sh & keep;
      if (f3 < 3'd3 && sh[8 * nbytes - 1]) m_load_val = m_load_val | ~keep;
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      exp_valid = m_req && cyc >= 1 && cyc <= req_last;
      check_output("req_valid", 64'(mem_req_valid), 64'(exp_valid));
      if (exp_valid) begin
        check_output("req_addr", mem_req_addr, m_addr);
        check_output("req_write", 64'(mem_req_write), 64'(m_write));
        if (m_write) begin
          check_output("req_wdata", mem_req_wdata, m_wdata);
          check_output("req_wstrb", 64'(mem_req_wstrb), 64'(m_wstrb));
        end
      end
      check_output("complete", 64'(complete), 64'(txn_en && cyc >= done_cyc));
      if (!m_abort && cyc >= done_cyc) begin
        check_output("alu_result_out", alu_result_out, m_alu);
        check_output("mem_load_data", mem_load_data, m_load_val);
        check_output("misaligned", 64'(misaligned), 64'(m_mis));
      end
    end
  end

  task automatic reset_mid();
    #2 reset = 1'b0;
    #1 active = 1'b0;
    check_output("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check_output("rst_complete", 64'(complete), 64'd0);
    check_output("rst_alu_out", alu_result_out, 64'd0);
    check_output("rst_load_data", mem_load_data, 64'd0);
    check_output("rst_misaligned", 64'(misaligned), 64'd0);
    enable = 1'b0; txn_en = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 mem_resp_valid = 1'b1;
    @(posedge clk); #1 mem_resp_valid = 1'b0;
    @(negedge clk);
    check_output("late_resp_complete", 64'(complete), 64'd0);
    check_output("late_resp_valid", 64'(mem_req_valid), 64'd0);
    check_output("late_resp_load", mem_load_data, 64'd0);
  endtask

  task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] sdata, input logic [63:0] rdata,
                                input int stall, input int delay, input int abort_at,
                                input bit spurious, input int rst_at);
    int last_c;
    bit cut;
    model_txn(op, f3, addr, sdata, rdata);
    req_last = 1 + stall;
    resp_cyc = req_last + 1 + delay;
    done_cyc = m_req ? resp_cyc + 1 : 1;
    m_abort  = (abort_at != 0);
    last_c   = m_abort ? resp_cyc + 2 : done_cyc + 3;
    cut      = 1'b0;
    @(posedge clk); #1;
    cyc = 0;
    ctrl.op_code = op; ctrl.funct3 = f3;
    alu_result = addr; store_data = sdata; mem_resp_data = rdata;
    mem_req_ready = 1'b0; mem_resp_valid = spurious;
    enable = 1'b1; txn_en = 1'b1; active = 1'b1;
    for (int c = 1; c <= last_c && !cut; c++) begin
      @(posedge clk); #1;
      cyc = c;
      mem_req_ready  = m_req && (c == req_last);
      mem_resp_valid = (m_req && c == resp_cyc) || (spurious && c == 1);
      if (c == abort_at || c == done_cyc + 2) begin
        enable = 1'b0;
        txn_en = 1'b0;
      end
      if (c == rst_at) begin
        reset_mid();
        cut = 1'b1;
      end
    end
    if (!cut) begin
      @(negedge clk); #1 active = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; ctrl = '0; alu_result = '0; store_data = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    active = 1'b0; txn_en = 1'b0; m_abort = 1'b0; cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_complete", 64'(complete), 64'd0);
    check_output("reset_req_valid", 64'(mem_req_valid), 64'd0);
    check_output("reset_alu_out", alu_result_out, 64'd0);
    check_output("reset_load_data", mem_load_data, 64'd0);
    check_output("reset_misaligned", 64'(misaligned), 64'd0);
    check_output("reset_req_addr", mem_req_addr, 64'd0);
    check_output("reset_req_wstrb", 64'(mem_req_wstrb), 64'd0);
    reset = 1'b1;

    apply_stimulus(OP_ADD, 3'b000, 64'hDEAD_BEEF_0000_1234, 64'd0, 64'd0, 0, 0, 0, 1'b0, 0);
    check_output("add_alu_pin", alu_result_out, 64'hDEAD_BEEF_0000_1234);

    apply_stimulus(OP_LOAD, 3'b010, 64'h1004, 64'd0, 64'hAAAA_AAAA_8000_0001, 0, 0, 0, 1'b0, 0);
    check_output("lw_model_addr", m_addr, 64'h1000);
    check_output("lw_load_pin", mem_load_data, 64'hFFFF_FFFF_AAAA_AAAA);

    apply_stimulus(OP_LOAD, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0, 1'b0, 0);
    check_output("lb_load_pin", mem_load_data, 64'hFFFF_FFFF_FFFF_FF80);
    apply_stimulus(OP_LOAD, 3'b100, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0, 1'b0, 0);
    check_output("lbu_load_pin", mem_load_data, 64'h0000_0000_0000_0080);

    apply_stimulus(OP_STORE, 3'b001, 64'h2006, 64'h1234, 64'd0, 0, 0, 0, 1'b0, 0);
    check_output("sh_model_wdata", m_wdata, 64'h1234_0000_0000_0000);
    check_output("sh_model_wstrb", 64'(m_wstrb), 64'hC0);
    check_output("sh_model_addr", m_addr, 64'h2000);

    apply_stimulus(OP_STORE, 3'b011, 64'h3000, 64'h0123_4567_89AB_CDEF, 64'd0, 5, 0, 0, 1'b0, 0);
    check_output("stall_done_cycle", 64'(done_cyc), 64'd8);

    apply_stimulus(OP_LOAD, 3'b010, 64'h1006, 64'd0, 64'h1122_3344_5566_7788, 0, 0, 0, 1'b0, 0);
    check_output("lw_odd_load_pin", mem_load_data, CHECK_ALIGN ? 64'd0 : 64'h0000_0000_1122_3344);
    check_output("lw_odd_mis_pin", 64'(misaligned), CHECK_ALIGN ? 64'd1 : 64'd0);

    apply_stimulus(OP_LOAD, 3'b001, 64'h100A, 64'd0, 64'h0000_0000_BEEF_0000, 0, 2, 0, 1'b0, 0);
    check_output("lh_load_pin", mem_load_data, 64'hFFFF_FFFF_FFFF_BEEF);

    apply_stimulus(OP_LOAD, 3'b110, 64'h4004, 64'd0, 64'h8765_4321_0000_0000, 1, 1, 0, 1'b0, 0);
    check_output("lwu_load_pin", mem_load_data, 64'h0000_0000_8765_4321);

    apply_stimulus(OP_STORE, 3'b000, 64'h5007, 64'hAB, 64'd0, 0, 0, 0, 1'b0, 0);
    check_output("sb_model_wstrb", 64'(m_wstrb), 64'h80);

    apply_stimulus(OP_STORE, 3'b010, 64'h5004, 64'hCAFE_BABE, 64'd0, 2, 0, 0, 1'b1, 0);

    apply_stimulus(OP_LOAD, 3'b011, 64'h6000, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 0, 0, 1'b1, 0);
    check_output("ld_load_pin", mem_load_data, 64'h0123_4567_89AB_CDEF);

    apply_stimulus(OP_STORE, 3'b011, 64'h3003, 64'h0F0E_0D0C_0B0A_0908, 64'd0, 0, 0, 0, 1'b0, 0);

    apply_stimulus(OP_LOAD, 3'b101, 64'h7002, 64'd0, 64'h0000_0000_5555_0000, 2, 0, 2, 1'b0, 0);
    apply_stimulus(OP_ADD, 3'b000, 64'h44, 64'd0, 64'd0, 0, 0, 0, 1'b0, 0);

    apply_stimulus(OP_LOAD, 3'b011, 64'h8000, 64'd0, 64'hFFFF_0000_FFFF_0000, 3, 0, 0, 1'b0, 2);
    apply_stimulus(OP_ADD, 3'b000, 64'h55, 64'd0, 64'd0, 0, 0, 0, 1'b0, 0);

    apply_stimulus(OP_LOAD, 3'b011, 64'h8008, 64'd0, 64'h1234_5678_9ABC_DEF0, 0, 4, 0, 1'b0, 3);
    apply_stimulus(OP_ADD, 3'b000, 64'h66, 64'd0, 64'd0, 0, 0, 0, 1'b0, 0);
    check_output("add_after_reset_pin", alu_result_out, 64'h66);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 5-stage pipeline, sitting directly upstream of `write_back`. It takes the effective address from the ALU and the store data and issues exactly one 64-bit data-bus transaction per load or store. Load data is aligned and sign- or zero-extended into `mem_load_data` for `write_back`; the ALU result is forwarded alongside it. Non-memory instructions pass through with fixed latency.

## Interface

Parameters:
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data-bus width. Only 64 is supported.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  stage start from the pipeline controller. Held high until `complete` is seen.
- `complete`  out  1  result valid; stage finished.
- `control_signals`  in  `decoder_output`  uses `op_code` (`OP_LOAD`, `OP_STORE`) and `funct3`.
- `alu_result`  in  64  effective address for memory ops; pass-through value otherwise.
- `store_data`  in  64  rs2 value for stores.
- `alu_result_out`  out  64  registered copy of `alu_result`.
- `mem_load_data`  out  64  extended load result; 0 for non-loads.
- `misaligned`  out  1  access rejected for misalignment.
- `mem_req_valid`  out  1  bus request valid.
- `mem_req_ready`  in  1  bus accepts the request.
- `mem_req_addr`  out  64  8-byte-aligned address (`alu_result & ~7`).
- `mem_req_write`  out  1  1 for a store, 0 for a load.
- `mem_req_wdata`  out  64  store data shifted into byte lanes.
- `mem_req_wstrb`  out  8  byte-lane enables.
- `mem_resp_valid`  in  1  response valid, one cycle. Arrives for loads and stores.
- `mem_resp_data`  in  64  read data, for loads.

## Operation

- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE transitions:
  - `enable` high with a load or store: capture inputs, go to REQ.
  - `enable` high with any other op: capture inputs, go to DONE.
- REQ: `mem_req_valid`=1. Address, write flag, data and strobes stay stable until `mem_req_ready`=1, then go to WAIT_RESP.
- WAIT_RESP: on `mem_resp_valid`, loads register the extended data; go to DONE.
- DONE: `complete`=1 while `enable` is high. Go to IDLE when `enable` falls.
- Byte offset: `off = alu_result[2:0]`.
- Load extraction: `sh = mem_resp_data >> (8*off)`. Extension by `funct3`:
  - 000 LB: sext(sh[7:0])
  - 001 LH: sext(sh[15:0])
  - 010 LW: sext(sh[31:0])
  - 011 LD: sh
  - 100 LBU, 101 LHU, 110 LWU: zero-extended
- Store encoding (`funct3` 000/001/010/011 = SB/SH/SW/SD):
  - `mem_req_wdata = store_data << (8*off)`.
  - `mem_req_wstrb = ((1<<bytes)-1) << off`.
- Misaligned access (`off` not a multiple of the access size):
  - No bus request is issued.
  - Go straight to DONE with `misaligned`=1 and `mem_load_data`=0.
- `enable` dropping during REQ or WAIT_RESP:
  - The bus transaction still completes.
  - The FSM then returns to IDLE without asserting `complete`.
- `mem_resp_valid` in IDLE or REQ is ignored.

## Timing

- Reset values: all outputs 0, FSM in IDLE. Reset takes effect asynchronously: `mem_req_valid` drops immediately, including mid-transaction.
- Non-memory op: `complete` is high one cycle after `enable` is sampled.
- Load or store with ready/response both immediate: `complete` 3 cycles after `enable`. Each cycle of ready stall or response delay adds one cycle.
- `mem_load_data`, `alu_result_out` and `misaligned` are stable throughout DONE and hold their values in IDLE until the next capture.
- At most one outstanding transaction. `mem_req_valid` is never high outside REQ.

## Configuration

- Macro `MEM_ACCESS_MISALIGN_CHECK_EN`.
- Defined: misalignment is detected and rejected as described in Operation.
- Undefined:
  - `misaligned` is tied to 0.
  - Bits below the access size are cleared (for example, an LW at 0x1006 is performed as an LW at 0x1004).
  - The request is always issued.

## Test plan

- LW at 0x1004, `mem_resp_data`=0xAAAAAAAA_80000001 -> `mem_req_addr`=0x1000, `mem_load_data`=0xFFFFFFFF_AAAAAAAA, `complete` 3 cycles after `enable`.
- LB and LBU at 0x1003, `mem_resp_data`=0x00000000_80000000 -> 0xFFFFFFFF_FFFFFF80 and 0x00000000_00000080 respectively.
- SH at 0x2006, `store_data`=0x1234 -> `mem_req_addr`=0x2000, `mem_req_wdata`=0x1234_0000_0000_0000, `mem_req_wstrb`=0xC0, `mem_req_write`=1.
- `mem_req_ready` held low for 5 cycles -> `mem_req_valid` and all request fields stay stable; `complete` arrives 5 cycles later than in the no-stall case.
- LW at 0x1006 -> with the macro defined: no request, `misaligned`=1, `complete` after 1 cycle. With the macro undefined: request to 0x1000, data taken from byte 4.
- `reset` asserted in WAIT_RESP -> `mem_req_valid`=0, `complete`=0, FSM in IDLE. A response arriving later is ignored, and the next ADD gives `complete` after 1 cycle.
